// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run/step/halt sequencer.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_t;

    localparam logic [4:0]  STOP_REG_DEF = 5'd31;
    localparam logic [31:0] STOP_VAL_DEF = 32'd400;
    localparam logic [31:0] CNT_SAT      = 32'hFFFF_FFFF;

    // States in which the divider runs and the core may be clocked.
    function automatic logic is_active(run_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Key, core-observation and status signals of the run controller.
interface cpu_run_ctrl_if;
    import cpu_run_ctrl_pkg::*;

    logic        key_run;
    logic        key_step;
    logic        key_clr;
    logic [31:0] pc_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] bp_addr;
    logic        cpu_ce;
    run_state_t  state;
    logic        done;
    logic [31:0] cycle_count;

    modport master (
        output key_run, key_step, key_clr, pc_in, wb_en, wb_rd, wb_data, bp_addr,
        input  cpu_ce, state, done, cycle_count
    );

    modport slave (
        input  key_run, key_step, key_clr, pc_in, wb_en, wb_rd, wb_data, bp_addr,
        output cpu_ce, state, done, cycle_count
    );

endinterface

// File: rtl/cpu_run_ctrl_key_pulse.sv
// Raw button to one-clk pulse: 2-flop synchroniser, edge detect, registered pulse.
module key_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);

    logic [2:0] sync_q;
    logic       pulse_q;

    // Shift the key through the synchroniser and register the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 3'b000;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], key};
            pulse_q <= sync_q[1] & ~sync_q[2];
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing the single-cycle core's clock enable.
// Optional PC breakpoint: define RUN_CTRL_BKPT_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int          DIV_W    = 1,
    parameter logic [4:0]  STOP_REG = STOP_REG_DEF,
    parameter logic [31:0] STOP_VAL = STOP_VAL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_run_ctrl_if.slave  bus
);

    run_state_t  state_q, state_d;
    logic        done_q, done_d;
    logic [31:0] cnt_q;
    logic        run_p, step_p, clr_p;
    logic        tick, active, ce, stop_hit, bp_hit;

    key_pulse u_run  (.clk(clk), .rst_n(rst_n), .key(bus.key_run),  .pulse(run_p));
    key_pulse u_step (.clk(clk), .rst_n(rst_n), .key(bus.key_step), .pulse(step_p));
    key_pulse u_clr  (.clk(clk), .rst_n(rst_n), .key(bus.key_clr),  .pulse(clr_p));

    assign active = is_active(state_q);

    generate
        if (DIV_W == 0) begin : g_nodiv
            assign tick = 1'b1;
        end else begin : g_div
            logic [DIV_W-1:0] div_q;

            // Free-run while staying in RUN/STEP; restart from zero on every entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    div_q <= '0;
                end else if (is_active(state_d) && active) begin
                    div_q <= div_q + DIV_W'(1);
                end else begin
                    div_q <= '0;
                end
            end

            assign tick = &div_q;
        end
    endgenerate

`ifdef RUN_CTRL_BKPT_EN
    assign bp_hit = (state_q == ST_RUN) && tick && (bus.pc_in == bus.bp_addr);
`else
    logic unused_bp;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bus.pc_in, bus.bp_addr};
`endif

    // A breakpoint suppresses the pulse so the instruction at bp_addr stays unexecuted.
    assign ce       = tick && active && !bp_hit;
    assign stop_hit = ce && bus.wb_en && (bus.wb_rd == STOP_REG) && (bus.wb_data == STOP_VAL);

    // State and sticky-done registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; step beats run, stop beats run, done locks out keys.
    always_comb begin
        state_d = state_q;
        done_d  = done_q | stop_hit;
        case (state_q)
            ST_IDLE: begin
                if (!done_q && step_p)     state_d = ST_STEP;
                else if (!done_q && run_p) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_hit || bp_hit || run_p) state_d = ST_HALT;
            end
            ST_STEP: begin
                if (ce) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!done_q && step_p)     state_d = ST_STEP;
                else if (!done_q && run_p) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Retired-cycle counter: clear wins over a coincident pulse, saturates at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_p) begin
            cnt_q <= '0;
        end else if (ce && (cnt_q != CNT_SAT)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.cpu_ce      = ce;
    assign bus.state       = state_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV_W=1 (core advances every 2 clk).
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int K_RUN  = 0;
    localparam int K_STEP = 1;
    localparam int K_CLR  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(.DIV_W(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Core model: PC advances by one instruction per issued clock enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.pc_in <= 32'd0;
        else if (bus.cpu_ce) bus.pc_in <= bus.pc_in + 32'd4;
    end

    task automatic set_key(input int k, input logic v);
        case (k)
            K_RUN:   bus.key_run  = v;
            K_STEP:  bus.key_step = v;
            default: bus.key_clr  = v;
        endcase
    endtask

    // Returns at the negedge after the resulting state change.
    task automatic press(input int k);
        @(negedge clk);
        set_key(k, 1'b1);
        repeat (3) @(negedge clk);
        set_key(k, 1'b0);
        @(negedge clk);
    endtask

    task automatic wait_ce(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.key_run = 1'b0; bus.key_step = 1'b0; bus.key_clr = 1'b0;
        bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int ce_n;
        bus.key_run = 1'b0; bus.key_step = 1'b0; bus.key_clr = 1'b0;
        bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0; bus.bp_addr = 32'h20;
        #2;
        n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        n_tests++; if (bus.cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b exp 0", bus.cpu_ce); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_tests++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0h exp 0", bus.cycle_count); end
        @(negedge clk);
        rst_n = 1'b1;
        ce_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) ce_n++;
        end
        n_tests++; if (ce_n !== 0) begin n_fail++; $display("FAIL idle_no_ce got %0d exp 0", ce_n); end
        n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL idle_state got %0d exp 0", bus.state); end
    endtask

    task automatic test_run();
        int pulses, last, bad_gap, first;
        do_reset();
        press(K_RUN);
        n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL run_enter got %0d exp 1", bus.state); end
        pulses = 0; last = 0; bad_gap = 0; first = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (bus.cpu_ce) begin
                if (pulses == 0) first = cyc;
                else if (cyc - last != 2) bad_gap++;
                last = cyc;
                pulses++;
                if (pulses == 10) break;
            end
        end
        n_tests++; if (pulses !== 10) begin n_fail++; $display("FAIL run_pulses got %0d exp 10", pulses); end
        n_tests++; if (first !== 1) begin n_fail++; $display("FAIL run_first_ce got %0d exp 1", first); end
        n_tests++; if (bad_gap !== 0) begin n_fail++; $display("FAIL run_ce_spacing got %0d bad gaps exp 0", bad_gap); end
        @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'd10) begin n_fail++; $display("FAIL run_count got %0d exp 10", bus.cycle_count); end
        press(K_RUN);
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL pause_state got %0d exp 3", bus.state); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL pause_no_ce got %0d exp 0", pulses); end
    endtask

    task automatic test_step();
        int pulses;
        do_reset();
        press(K_STEP);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL step_one_ce got %0d exp 1", pulses); end
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL step_halt got %0d exp 3", bus.state); end
        n_tests++; if (bus.cycle_count !== 32'd1) begin n_fail++; $display("FAIL step_count1 got %0d exp 1", bus.cycle_count); end
        press(K_STEP);
        repeat (6) @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'd2) begin n_fail++; $display("FAIL step_count2 got %0d exp 2", bus.cycle_count); end
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL step2_halt got %0d exp 3", bus.state); end
    endtask

    task automatic test_stop();
        bit ok;
        int pulses;
        do_reset();
        press(K_RUN);
        wait_ce(10, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stop_wait_ce got timeout exp pulse"); end
        bus.wb_en = 1'b1; bus.wb_rd = 5'd31; bus.wb_data = 32'd400;
        @(negedge clk);
        bus.wb_en = 1'b0;
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL stop_state got %0d exp 3", bus.state); end
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL stop_done got %b exp 1", bus.done); end
        n_tests++; if (bus.cycle_count !== 32'd1) begin n_fail++; $display("FAIL stop_counted got %0d exp 1", bus.cycle_count); end
        press(K_RUN);
        press(K_STEP);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cpu_ce) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL done_locks_keys got %0d ce exp 0", pulses); end
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL done_state got %0d exp 3", bus.state); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_reset got %b exp 0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_stop();
        bit ok;
        do_reset();
        press(K_RUN);
        wait_ce(10, ok);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd31; bus.wb_data = 32'd399;
        @(negedge clk);
        bus.wb_en = 1'b0;
        n_tests++; if (bus.state !== ST_RUN || bus.done !== 1'b0) begin n_fail++; $display("FAIL nostop_val got state %0d done %b exp 1 0", bus.state, bus.done); end
        wait_ce(10, ok);
        bus.wb_en = 1'b1; bus.wb_rd = 5'd30; bus.wb_data = 32'd400;
        @(negedge clk);
        bus.wb_en = 1'b0;
        n_tests++; if (bus.state !== ST_RUN || bus.done !== 1'b0) begin n_fail++; $display("FAIL nostop_rd got state %0d done %b exp 1 0", bus.state, bus.done); end
        n_tests++; if (bus.cycle_count !== 32'd2) begin n_fail++; $display("FAIL nostop_count got %0d exp 2", bus.cycle_count); end
        wait_ce(10, ok);
        bus.wb_en = 1'b0; bus.wb_rd = 5'd31; bus.wb_data = 32'd400;
        @(negedge clk);
        n_tests++; if (bus.state !== ST_RUN || bus.done !== 1'b0) begin n_fail++; $display("FAIL nostop_en got state %0d done %b exp 1 0", bus.state, bus.done); end
        bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    endtask

    task automatic test_clr_with_ce();
        do_reset();
        press(K_RUN);
        bus.key_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.key_clr = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.cpu_ce !== 1'b1) begin n_fail++; $display("FAIL clr_overlap_ce got %b exp 1", bus.cpu_ce); end
        @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", bus.cycle_count); end
        n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL clr_state got %0d exp 1", bus.state); end
        repeat (2) @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'd1) begin n_fail++; $display("FAIL clr_resume got %0d exp 1", bus.cycle_count); end
    endtask

    task automatic test_saturate();
        bit ok;
        do_reset();
        force dut.cnt_q = 32'hFFFF_FFFD;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sat_preload got %0h exp fffffffd", bus.cycle_count); end
        press(K_RUN);
        for (int i = 0; i < 5; i++) wait_ce(10, ok);
        @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold got %0h exp ffffffff", bus.cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        do_reset();
        press(K_RUN);
        wait_ce(10, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_wait_ce got timeout exp pulse"); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.cpu_ce !== 1'b0) begin n_fail++; $display("FAIL midrst_ce got %b exp 0", bus.cpu_ce); end
        n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state got %0d exp 0", bus.state); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", bus.done); end
        n_tests++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL midrst_count got %0d exp 0", bus.cycle_count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_breakpoint();
        int guard;
        do_reset();
        bus.bp_addr = 32'h20;
        press(K_RUN);
`ifdef RUN_CTRL_BKPT_EN
        guard = 0;
        while (bus.state !== ST_HALT && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_tests++; if (bus.state !== ST_HALT) begin n_fail++; $display("FAIL bp_halt got %0d exp 3", bus.state); end
        n_tests++; if (bus.cycle_count !== 32'd8) begin n_fail++; $display("FAIL bp_count got %0d exp 8", bus.cycle_count); end
        n_tests++; if (bus.pc_in !== 32'h20) begin n_fail++; $display("FAIL bp_pc got %0h exp 20", bus.pc_in); end
        press(K_STEP);
        repeat (6) @(negedge clk);
        n_tests++; if (bus.cycle_count !== 32'd9) begin n_fail++; $display("FAIL bp_step_count got %0d exp 9", bus.cycle_count); end
        n_tests++; if (bus.pc_in !== 32'h24) begin n_fail++; $display("FAIL bp_step_pc got %0h exp 24", bus.pc_in); end
`else
        guard = 0;
        while (bus.cycle_count < 32'd12 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_tests++; if (bus.cycle_count < 32'd12) begin n_fail++; $display("FAIL nobp_progress got %0d exp >=12", bus.cycle_count); end
        n_tests++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL nobp_state got %0d exp 1", bus.state); end
`endif
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_stop();
        test_no_stop();
        test_clr_with_ce();
        test_saturate();
        test_reset_mid_run();
        test_breakpoint();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/halt sequencer for the single-cycle CPU core. Produces the core's clock-enable pulse from the board clock, advances the core on run or single-step key commands, and halts it on a stop write-back or an optional PC breakpoint. Counts retired CPU cycles for the benchmark display, replacing the free-running divider-plus-flag scheme.

## Interface
Parameters:
- DIV_W, 1: core advances once every 2^DIV_W clk cycles; 0 means every cycle.
- STOP_REG, 5'd31: destination register watched for the stop condition.
- STOP_VAL, 32'd400: value whose write to STOP_REG halts the core.

Ports:
- clk  in  1  board clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- key_run  in  1  raw run/pause button (asynchronous, level).
- key_step  in  1  raw single-step button.
- key_clr  in  1  raw counter-clear button.
- pc_in  in  32  core PC of the instruction about to execute.
- wb_en  in  1  core register-file write enable for the current instruction.
- wb_rd  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- bp_addr  in  32  breakpoint PC (only with RUN_CTRL_BKPT_EN).
- cpu_ce  out  1  one-clk core clock-enable pulse.
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- done  out  1  sticky: stop condition reached.
- cycle_count  out  32  number of cpu_ce pulses issued.

## Operation
- Keys: 2-flop synchroniser followed by a rising-edge detector. This gives a one-clk pulse per press. No debounce; buttons are debounced on the board.
- Divider div_cnt[DIV_W-1:0]:
  - Free-runs only in RUN/STEP.
  - Cleared on entry to IDLE/HALT.
  - tick = (div_cnt == all-ones); tick is constant 1 when DIV_W=0.
- cpu_ce = tick and (state is RUN or STEP) and not bp_hit.
- FSM:
  - IDLE --run--> RUN; IDLE --step--> STEP.
  - RUN --run--> HALT (pause); RUN --stop or bp_hit--> HALT.
  - STEP --cpu_ce issued--> HALT.
  - HALT --run--> RUN; HALT --step--> STEP.
  - While done=1, run and step pulses are ignored; only reset leaves that condition.
- Stop condition:
  - Sampled only in a cycle with cpu_ce=1: wb_en and wb_rd==STOP_REG and wb_data==STOP_VAL.
  - That instruction commits and is counted.
  - The next state is HALT and done is set.
- Simultaneous key pulses in one cycle: step has priority over run. clr is independent and applies in parallel.
- Simultaneous stop and run pulse: stop wins, giving HALT with done=1.
- cycle_count:
  - Increments on every cpu_ce.
  - Saturates at 32'hFFFF_FFFF.
  - A clr pulse sets it to 0. If clr and cpu_ce occur together, the result is 0.
  - clr does not change state or done.

## Timing
- Reset values: state=IDLE, cpu_ce=0, done=0, cycle_count=0, div_cnt=0, synchronisers=0.
- Key sampled high at edge n: pulse valid after edge n+2, state changes at edge n+3.
- First cpu_ce in RUN: 2^DIV_W cycles after entering RUN (1 cycle when DIV_W=0).
- cpu_ce and cycle_count are registered-consistent: cycle_count reflects a pulse on the edge that ends that pulse.
- Reset mid-RUN: cpu_ce drops asynchronously. A pulse cut short counts as not issued.

## Configuration
- RUN_CTRL_BKPT_EN defined: bp_hit = (state==RUN) and tick and (pc_in==bp_addr).
  - On bp_hit, cpu_ce is suppressed and the FSM goes to HALT, so the instruction at bp_addr has not executed.
  - A subsequent step executes it. The breakpoint is not re-checked in STEP.
  - Run from HALT re-checks at the next tick; step once first to pass the breakpoint.
- RUN_CTRL_BKPT_EN undefined: bp_hit is constant 0, bp_addr is unused, and no comparator is built.

## Structure
- Package cpu_run_ctrl_pkg holds:
  - the state encoding (IDLE/RUN/STEP/HALT as a 2-bit typedef);
  - the STOP_REG/STOP_VAL defaults;
  - the saturation constant.
- Sub-module key_pulse: 2-flop synchroniser plus edge detector. Instantiated three times (run, step, clr).

## Test plan
- Reset, DIV_W=1, press run. cpu_ce pulses every 2 clk. After 10 pulses, cycle_count=10.
- Press step from IDLE. Exactly one cpu_ce, then state=HALT. A second step gives cycle_count=2.
- In RUN, drive wb_en=1, wb_rd=31, wb_data=400 on a cpu_ce cycle. That pulse is counted, the next state is HALT, done=1, and later run presses produce no cpu_ce.
- Same write-back with wb_data=399 or wb_rd=30 gives no halt.
- With RUN_CTRL_BKPT_EN, bp_addr=0x20:
  - When pc_in reaches 0x20, no cpu_ce is issued and state=HALT with cycle_count unchanged.
  - A step then issues one cpu_ce.
- Preload cycle_count near saturation via a long run (or force). It holds at 0xFFFFFFFF.
- clr pulse coinciding with cpu_ce gives cycle_count=0 while state stays RUN.
- Assert rst_n low mid-RUN. cpu_ce=0, state=IDLE and done=0 immediately.
